// File: rtl/riscv_defines.sv
// Shared TPR field positions, ALU tag modes and store-tag types for the tag-propagation datapath.
package riscv_defines;

  localparam int unsigned ALU_MODE_WIDTH = 3;

  localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_AND   = 3'd0;
  localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_OR    = 3'd1;
  localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_CLEAR = 3'd2;
  localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_OLD   = 3'd3;

  localparam int unsigned LOADSTORE_LOW             = 19;
  localparam int unsigned LOADSTORE_HIGH            = 21;
  localparam int unsigned LOADSTORE_EN_SOURCE       = 22;
  localparam int unsigned LOADSTORE_EN_SOURCE_ADDR  = 23;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } store_tag_fsm_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wdata;
    logic [3:0]  be;
  } store_tag_entry_t;

endpackage

// File: rtl/riscv_store_tag_fifo.sv
// Pending tag-write queue. STORE_TAG_BUFFER_EN selects a 2-entry circular FIFO;
// otherwise a single holding register.
module riscv_store_tag_fifo
  import riscv_defines::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  store_tag_entry_t entry_i,
  input  logic             pop_i,
  output store_tag_entry_t head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             more_o
);

`ifdef STORE_TAG_BUFFER_EN
  store_tag_entry_t mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i & (count_q != 2'd2);
  assign pop_ok  = pop_i & (count_q != 2'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + push_ok;
    rd_ptr_d = rd_ptr_q + pop_ok;
    count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign more_o  = (count_q == 2'd2);
`else
  store_tag_entry_t entry_q, entry_d;
  logic             valid_q, valid_d;

  always_comb begin
    valid_d = (valid_q & ~pop_i) | push_i;
    entry_d = push_i ? entry_i : entry_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign head_o  = entry_q;
  assign empty_o = ~valid_q;
  assign full_o  = valid_q;
  assign more_o  = 1'b0;
`endif

endmodule

// File: rtl/riscv_store_propagation.sv
// Store tag propagation: computes the store tag from the TPR and issues tag-memory writes
// through a req/gnt/rvalid handshake. Queue depth set by STORE_TAG_BUFFER_EN.
module riscv_store_propagation
  import riscv_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        store_valid_i,
  output logic        store_ready_o,
  input  logic [31:0] store_addr_i,
  input  logic [3:0]  store_be_i,
  input  logic        rs1_i_tag,
  input  logic        rs2_i_tag,
  input  logic [31:0] tpr_i,
  output logic        tag_req_o,
  input  logic        tag_gnt_i,
  output logic [31:0] tag_addr_o,
  output logic [3:0]  tag_wdata_o,
  output logic [3:0]  tag_be_o,
  input  logic        tag_rvalid_i,
  output logic        busy_o
);

  logic [ALU_MODE_WIDTH-1:0] mode;
  logic                      op_a, op_b, tag;
  logic                      accept, push, pop;
  logic                      fifo_empty, fifo_full, fifo_more;
  store_tag_entry_t          new_entry, head;
  store_tag_fsm_e            state_q, state_d;
  logic                      unused_bits;

  assign mode = tpr_i[LOADSTORE_HIGH:LOADSTORE_LOW];
  assign op_a = rs1_i_tag & tpr_i[LOADSTORE_EN_SOURCE_ADDR];
  assign op_b = rs2_i_tag & tpr_i[LOADSTORE_EN_SOURCE];

  always_comb begin
    tag = 1'b0;
    case (mode)
      ALU_MODE_AND: tag = op_a & op_b;
      ALU_MODE_OR:  tag = op_a | op_b;
      default:      tag = 1'b0;
    endcase
  end

`ifdef STORE_TAG_BUFFER_EN
  assign store_ready_o = ~rst & ~fifo_full;
`else
  assign store_ready_o = ~rst & ~fifo_full & (state_q == IDLE);
`endif

  // OLD mode and empty byte enables are accepted but leave memory tags untouched.
  assign accept    = store_valid_i & store_ready_o;
  assign push      = accept & (mode != ALU_MODE_OLD) & (|store_be_i);
  assign new_entry = '{addr: {store_addr_i[31:2], 2'b00}, wdata: {4{tag}}, be: store_be_i};

  riscv_store_tag_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (new_entry),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .more_o  (fifo_more)
  );

  // Leaving IDLE on the incoming push gives the one-cycle accept-to-request latency.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty || push) state_d = REQ;
      REQ:  if (tag_gnt_i) state_d = WAIT;
      WAIT: begin
        if (tag_rvalid_i) begin
          pop     = 1'b1;
          state_d = (fifo_more || push) ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign tag_req_o   = ~rst & (state_q == REQ);
  assign tag_addr_o  = tag_req_o ? head.addr  : '0;
  assign tag_wdata_o = tag_req_o ? head.wdata : '0;
  assign tag_be_o    = tag_req_o ? head.be    : '0;
  assign busy_o      = ~rst & ~fifo_empty;

  assign unused_bits = ^{store_addr_i[1:0], tpr_i};

endmodule

// File: tb/tb_riscv_store_propagation.sv
// Directed and randomized bench for riscv_store_propagation against a queue-based reference model.
module tb_riscv_store_propagation;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        store_valid_i, store_ready_o;
  logic [31:0] store_addr_i;
  logic [3:0]  store_be_i;
  logic        rs1_i_tag, rs2_i_tag;
  logic [31:0] tpr_i;
  logic        tag_req_o, tag_gnt_i, tag_rvalid_i, busy_o;
  logic [31:0] tag_addr_o;
  logic [3:0]  tag_wdata_o, tag_be_o;

  riscv_store_propagation dut (
    .clk           (clk),
    .rst           (rst),
    .store_valid_i (store_valid_i),
    .store_ready_o (store_ready_o),
    .store_addr_i  (store_addr_i),
    .store_be_i    (store_be_i),
    .rs1_i_tag     (rs1_i_tag),
    .rs2_i_tag     (rs2_i_tag),
    .tpr_i         (tpr_i),
    .tag_req_o     (tag_req_o),
    .tag_gnt_i     (tag_gnt_i),
    .tag_addr_o    (tag_addr_o),
    .tag_wdata_o   (tag_wdata_o),
    .tag_be_o      (tag_be_o),
    .tag_rvalid_i  (tag_rvalid_i),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

`ifdef STORE_TAG_BUFFER_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t        mq[$];
  bit          outstanding;
  bit          acc_last;
  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] make_tpr(logic [ALU_MODE_WIDTH-1:0] m, bit ea, bit eb);
    logic [31:0] t;
    t = $urandom;
    t[LOADSTORE_HIGH:LOADSTORE_LOW] = m;
    t[LOADSTORE_EN_SOURCE_ADDR]     = ea;
    t[LOADSTORE_EN_SOURCE]          = eb;
    return t;
  endfunction

  // One clock cycle: drive at the falling edge, compare against the model, then advance it.
  task automatic step(bit v, logic [31:0] a, logic [3:0] be, bit r1, bit r2,
                      logic [31:0] tpr, bit gnt, bit rv);
    bit exp_ready, exp_req, ta, tb_, tg;
    logic [ALU_MODE_WIDTH-1:0] m;
    store_valid_i = v; store_addr_i = a; store_be_i = be;
    rs1_i_tag = r1; rs2_i_tag = r2; tpr_i = tpr;
    tag_gnt_i = gnt; tag_rvalid_i = rv;
    #1;
    exp_ready = (mq.size() < CAP);
    exp_req   = (mq.size() > 0) && !outstanding;
    check("ready", {31'b0, store_ready_o}, {31'b0, exp_ready});
    check("req",   {31'b0, tag_req_o},     {31'b0, exp_req});
    check("busy",  {31'b0, busy_o},        {31'b0, mq.size() > 0});
    if (exp_req) begin
      check("addr",  tag_addr_o,          mq[0].addr);
      check("wdata", {28'b0, tag_wdata_o}, {28'b0, mq[0].wdata});
      check("be",    {28'b0, tag_be_o},    {28'b0, mq[0].be});
    end
    acc_last = v && exp_ready;
    if (exp_req && gnt) outstanding = 1;
    else if (outstanding && rv) begin
      mq.delete(0);
      outstanding = 0;
    end
    m   = tpr[LOADSTORE_HIGH:LOADSTORE_LOW];
    ta  = r1 && tpr[LOADSTORE_EN_SOURCE_ADDR];
    tb_ = r2 && tpr[LOADSTORE_EN_SOURCE];
    tg  = (m == ALU_MODE_AND) ? (ta && tb_) : (m == ALU_MODE_OR) ? (ta || tb_) : 1'b0;
    if (acc_last && m != ALU_MODE_OLD && be != 4'b0000)
      mq.push_back('{addr: {a[31:2], 2'b00}, wdata: tg ? 4'hF : 4'h0, be: be});
    @(negedge clk);
  endtask

  task automatic idle(bit gnt, bit rv);
    step(0, $urandom, $urandom, $urandom, $urandom, $urandom, gnt, rv);
  endtask

  task automatic do_reset(int unsigned n);
    rst = 1'b1;
    repeat (n) begin
      store_valid_i = 1'b1; tag_gnt_i = $urandom; tag_rvalid_i = $urandom;
      #1;
      check("rst_ready", {31'b0, store_ready_o}, 32'd0);
      check("rst_req",   {31'b0, tag_req_o},     32'd0);
      check("rst_busy",  {31'b0, busy_o},        32'd0);
      check("rst_addr",  tag_addr_o,             32'd0);
      check("rst_wdata", {28'b0, tag_wdata_o},   32'd0);
      check("rst_be",    {28'b0, tag_be_o},      32'd0);
      @(negedge clk);
    end
    rst = 1'b0;
    mq.delete();
    outstanding = 0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((mq.size() > 0 || outstanding) && n < 60) begin
      idle($urandom, $urandom);
      n++;
    end
    check("drain_empty", mq.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] t;
    int unsigned n;
    rst = 1'b1; store_valid_i = 0; store_addr_i = 0; store_be_i = 0;
    rs1_i_tag = 0; rs2_i_tag = 0; tpr_i = 0; tag_gnt_i = 0; tag_rvalid_i = 0;
    @(negedge clk);
    do_reset(2);

    // OR mode, both enables: word-aligned address, replicated tag, request one cycle later.
    t = make_tpr(ALU_MODE_OR, 1, 1);
    step(1, 32'h1006, 4'b1100, 0, 1, t, 0, 0);
    check("d41_acc", {31'b0, acc_last}, 32'd1);
    #1;
    check("d41_req",   {31'b0, tag_req_o},   32'd1);
    check("d41_addr",  tag_addr_o,           32'h1004);
    check("d41_wdata", {28'b0, tag_wdata_o}, 32'hF);
    check("d41_be",    {28'b0, tag_be_o},    32'hC);
    drain();

    // AND mode with the address enable off clears the tag.
    t = make_tpr(ALU_MODE_AND, 0, 1);
    step(1, 32'h2000, 4'b1111, 1, 1, t, 0, 0);
    #1;
    check("d42_req",   {31'b0, tag_req_o},   32'd1);
    check("d42_wdata", {28'b0, tag_wdata_o}, 32'h0);
    drain();

    // OLD mode: accepted, nothing issued.
    t = make_tpr(ALU_MODE_OLD, 1, 1);
    step(1, 32'h3000, 4'b1111, 1, 1, t, 0, 0);
    check("d43_acc", {31'b0, acc_last}, 32'd1);
    repeat (5) begin
      idle(0, 0);
      check("d43_req",  {31'b0, tag_req_o}, 32'd0);
      check("d43_busy", {31'b0, busy_o},    32'd0);
    end

`ifdef STORE_TAG_BUFFER_EN
    // Three back-to-back stores with the grant withheld: the third stalls.
    t = make_tpr(ALU_MODE_OR, 1, 1);
    step(1, 32'h4000, 4'h1, 1, 0, t, 0, 0);
    check("d44_acc1", {31'b0, acc_last}, 32'd1);
    step(1, 32'h4010, 4'h2, 0, 0, t, 0, 0);
    check("d44_acc2", {31'b0, acc_last}, 32'd1);
    repeat (5) begin
      step(1, 32'h4020, 4'h4, 0, 1, t, 0, 0);
      check("d44_stall3", {31'b0, acc_last}, 32'd0);
    end
    n = 0;
    do begin
      step(1, 32'h4020, 4'h4, 0, 1, t, 1, 1);
      n++;
    end while (!acc_last && n < 20);
    check("d44_acc3", {31'b0, acc_last}, 32'd1);
    drain();
`else
    // Single holding register: second store waits for the first completion.
    t = make_tpr(ALU_MODE_OR, 1, 0);
    step(1, 32'h5000, 4'h3, 1, 0, t, 0, 0);
    check("d46_acc1", {31'b0, acc_last}, 32'd1);
    repeat (3) begin
      step(1, 32'h5010, 4'h8, 0, 0, t, 0, 0);
      check("d46_stall", {31'b0, acc_last}, 32'd0);
    end
    step(1, 32'h5010, 4'h8, 0, 0, t, 1, 0);
    check("d46_stall_gnt", {31'b0, acc_last}, 32'd0);
    step(1, 32'h5010, 4'h8, 0, 0, t, 0, 1);
    check("d46_stall_rv", {31'b0, acc_last}, 32'd0);
    step(1, 32'h5010, 4'h8, 0, 0, t, 0, 0);
    check("d46_acc2", {31'b0, acc_last}, 32'd1);
    drain();
`endif

    // Reset while waiting for completion, then a stray response.
    t = make_tpr(ALU_MODE_OR, 1, 1);
    step(1, 32'h6000, 4'hF, 1, 1, t, 0, 0);
    idle(1, 0);
    idle(0, 0);
    do_reset(1);
    idle(0, 1);
    check("d45_busy", {31'b0, busy_o},    32'd0);
    check("d45_req",  {31'b0, tag_req_o}, 32'd0);
    step(1, 32'h6100, 4'h5, 1, 1, t, 0, 1);
    check("d45_acc", {31'b0, acc_last}, 32'd1);
    #1;
    check("d45_req2",  {31'b0, tag_req_o}, 32'd1);
    check("d45_busy2", {31'b0, busy_o},    32'd1);
    drain();

    // Random traffic including stray handshakes, zero byte enables and occasional reset.
    repeat (400) begin
      if ($urandom_range(0, 99) == 0) do_reset(1);
      else step($urandom_range(0, 1),
                $urandom,
                ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
                $urandom_range(0, 1), $urandom_range(0, 1),
                make_tpr(ALU_MODE_WIDTH'($urandom_range(0, (1 << ALU_MODE_WIDTH) - 1)),
                         $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1),
                $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
